id_exe_pipe_reg: RTL and testbench
==================================

ID_EXE_PIPE_REG -- requirements
Module: id_exe_pipe_reg

Interface
REQ-001 Parameters: none at top level; sub-module pipe_field_reg has WIDTH, default 32, field bit width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 write  input  1  capture enable; 1 = load inputs at edge, 0 = hold.
REQ-005 pcPlus4In / pcPlus4Out  input / output  32  PC+4 of the instruction.
REQ-006 imm32In / imm32Out  input / output  32  sign/zero-extended immediate.
REQ-007 regData1In / regData1Out  input / output  32  register file read port 1 data.
REQ-008 regData2In / regData2Out  input / output  32  register file read port 2 data.
REQ-009 instrRtIn / instrRtOut  input / output  5  rt field.
REQ-010 instrRdIn / instrRdOut  input / output  5  rd field.
REQ-011 shamtIn / shamtOut  input / output  5  shift amount.
REQ-012 aluOpIn / aluOpOut  input / output  4  ALU operation code.
REQ-013 aluSrc, shift, regDst, regWrite, branch, memToReg  In input / Out output  1 each  EXE/WB control bits.
REQ-014 memWrite, memRead, loadFullWord, loadSigned  In input / Out output  1 each  MEM control bits.

Function
REQ-015 Every xxxOut SHALL be a registered copy of xxxIn; no combinational path from any input to any output.
REQ-016 At a rising clk edge with reset=0: every output SHALL become 0, regardless of write.
REQ-017 At a rising clk edge with reset=1 and write=1: every output SHALL take the value its input had at that edge (latency exactly 1 cycle).
REQ-018 At a rising clk edge with reset=1 and write=0: every output SHALL hold its previous value (stall).
REQ-019 Between edges outputs SHALL not change, whatever the inputs, write or reset do.
REQ-020 aluOpOut SHALL be exactly 4 bits wide; any internal widening SHALL zero-fill and not be visible at ports.
REQ-021 All fields SHALL share the one write enable; partial-field updates SHALL not exist.
REQ-022 Before the first reset or write edge outputs are unspecified; benches SHALL not check them.

Reset
REQ-023 Reset SHALL be synchronous, active-low, sampled only at rising clk, and SHALL take priority over write.
REQ-024 Reset value of every output SHALL be 0 (all bits); reset asserted mid-run SHALL clear all fields at the next edge, deassertion resumes normal capture the following edge.

Structure
REQ-025 One sub-module pipe_field_reg (parameter WIDTH) implementing a WIDTH-bit enabled, sync-active-low-reset register; instantiate once per field (WIDTH 32, 5, 4, 1).
REQ-026 Shared package SHALL hold the widths: WORD_W=32, REG_ADDR_W=5, SHAMT_W=5, ALU_OP_W=4.
REQ-027 No other logic (no muxing, no flush input) SHALL exist in the block; flush is done by the driver forcing control inputs to 0.

Verification
REQ-028 reset=0 one edge, inputs all-ones, write=1 -> all outputs 0.
REQ-029 reset=1, write=1, pcPlus4In=32'h4, instrRdIn=5, aluOpIn=4, branchIn=0 -> after one edge pcPlus4Out=32'h4, instrRdOut=5, aluOpOut=4, branchOut=0.
REQ-030 After REQ-029, write=0, pcPlus4In=32'h8, aluOpIn=4'hF, branchIn=1 for 3 edges -> outputs stay 32'h4, 4, 0.
REQ-031 reset=1, write=1, every input all-ones -> one edge later every output all-ones (aluOpOut=4'hF, 1-bit outs=1).
REQ-032 reset=0 and write=1 same edge with nonzero inputs -> all outputs 0 (reset priority); next edge reset=1 -> outputs equal inputs.
REQ-033 Inputs toggled between edges with write=1 -> outputs change only at rising edges, never mid-cycle.

Source files
------------

// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared field widths for the ID/EXE pipeline register.
package id_exe_pipe_reg_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned CTRL_W     = 10;

endpackage

// File: rtl/id_exe_pipe_reg_field.sv
// WIDTH-bit register with load enable and synchronous active-low clear.
module pipe_field_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (write) val_d = d;
  end

  // Clear wins over load because it is checked first.
  always_ff @(posedge clk) begin
    if (!reset) val_q <= '0;
    else        val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register: every field captured on one shared enable.
module id_exe_pipe_reg
  import id_exe_pipe_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [WORD_W-1:0]     pcPlus4In,
  input  logic [WORD_W-1:0]     imm32In,
  input  logic [WORD_W-1:0]     regData1In,
  input  logic [WORD_W-1:0]     regData2In,
  input  logic [REG_ADDR_W-1:0] instrRtIn,
  input  logic [REG_ADDR_W-1:0] instrRdIn,
  input  logic [SHAMT_W-1:0]    shamtIn,
  input  logic [ALU_OP_W-1:0]   aluOpIn,
  input  logic                  aluSrcIn,
  input  logic                  shiftIn,
  input  logic                  regDstIn,
  input  logic                  regWriteIn,
  input  logic                  branchIn,
  input  logic                  memToRegIn,
  input  logic                  memWriteIn,
  input  logic                  memReadIn,
  input  logic                  loadFullWordIn,
  input  logic                  loadSignedIn,
  output logic [WORD_W-1:0]     pcPlus4Out,
  output logic [WORD_W-1:0]     imm32Out,
  output logic [WORD_W-1:0]     regData1Out,
  output logic [WORD_W-1:0]     regData2Out,
  output logic [REG_ADDR_W-1:0] instrRtOut,
  output logic [REG_ADDR_W-1:0] instrRdOut,
  output logic [SHAMT_W-1:0]    shamtOut,
  output logic [ALU_OP_W-1:0]   aluOpOut,
  output logic                  aluSrcOut,
  output logic                  shiftOut,
  output logic                  regDstOut,
  output logic                  regWriteOut,
  output logic                  branchOut,
  output logic                  memToRegOut,
  output logic                  memWriteOut,
  output logic                  memReadOut,
  output logic                  loadFullWordOut,
  output logic                  loadSignedOut
);

  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_out;

  pipe_field_reg #(.WIDTH(WORD_W)) u_pc_plus4 (
    .clk(clk), .reset(reset), .write(write), .d(pcPlus4In), .q(pcPlus4Out)
  );
  pipe_field_reg #(.WIDTH(WORD_W)) u_imm32 (
    .clk(clk), .reset(reset), .write(write), .d(imm32In), .q(imm32Out)
  );
  pipe_field_reg #(.WIDTH(WORD_W)) u_reg_data1 (
    .clk(clk), .reset(reset), .write(write), .d(regData1In), .q(regData1Out)
  );
  pipe_field_reg #(.WIDTH(WORD_W)) u_reg_data2 (
    .clk(clk), .reset(reset), .write(write), .d(regData2In), .q(regData2Out)
  );
  pipe_field_reg #(.WIDTH(REG_ADDR_W)) u_instr_rt (
    .clk(clk), .reset(reset), .write(write), .d(instrRtIn), .q(instrRtOut)
  );
  pipe_field_reg #(.WIDTH(REG_ADDR_W)) u_instr_rd (
    .clk(clk), .reset(reset), .write(write), .d(instrRdIn), .q(instrRdOut)
  );
  pipe_field_reg #(.WIDTH(SHAMT_W)) u_shamt (
    .clk(clk), .reset(reset), .write(write), .d(shamtIn), .q(shamtOut)
  );
  pipe_field_reg #(.WIDTH(ALU_OP_W)) u_alu_op (
    .clk(clk), .reset(reset), .write(write), .d(aluOpIn), .q(aluOpOut)
  );

  // Single-bit control flags are bundled so one generate loop covers them all.
  assign ctrl_in = {aluSrcIn, shiftIn, regDstIn, regWriteIn, branchIn,
                    memToRegIn, memWriteIn, memReadIn, loadFullWordIn, loadSignedIn};

  for (genvar i = 0; i < CTRL_W; i++) begin : g_ctrl
    pipe_field_reg #(.WIDTH(1)) u_bit (
      .clk(clk), .reset(reset), .write(write), .d(ctrl_in[i]), .q(ctrl_out[i])
    );
  end

  assign {aluSrcOut, shiftOut, regDstOut, regWriteOut, branchOut,
          memToRegOut, memWriteOut, memReadOut, loadFullWordOut, loadSignedOut} = ctrl_out;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg: directed table, random traffic, mid-cycle stability.
module tb_id_exe_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [3:0]  aluop;
    logic [9:0]  ctrl;  // {aluSrc,shift,regDst,regWrite,branch,memToReg,memWrite,memRead,loadFullWord,loadSigned}
  } fields_t;

  typedef struct {
    logic    rst_n;
    logic    wr;
    fields_t in;
    fields_t exp;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    wr;
  fields_t in_f;
  fields_t out_f;
  fields_t model;

  int checks = 0;
  int errors = 0;

  logic [31:0] pcPlus4In, imm32In, regData1In, regData2In;
  logic [31:0] pcPlus4Out, imm32Out, regData1Out, regData2Out;
  logic [4:0]  instrRtIn, instrRdIn, shamtIn, instrRtOut, instrRdOut, shamtOut;
  logic [3:0]  aluOpIn, aluOpOut;
  logic aluSrcIn, shiftIn, regDstIn, regWriteIn, branchIn, memToRegIn;
  logic memWriteIn, memReadIn, loadFullWordIn, loadSignedIn;
  logic aluSrcOut, shiftOut, regDstOut, regWriteOut, branchOut, memToRegOut;
  logic memWriteOut, memReadOut, loadFullWordOut, loadSignedOut;

  always #5 clk = ~clk;

  assign {pcPlus4In, imm32In, regData1In, regData2In, instrRtIn, instrRdIn, shamtIn, aluOpIn,
          aluSrcIn, shiftIn, regDstIn, regWriteIn, branchIn, memToRegIn,
          memWriteIn, memReadIn, loadFullWordIn, loadSignedIn} = in_f;
  assign out_f = {pcPlus4Out, imm32Out, regData1Out, regData2Out, instrRtOut, instrRdOut,
                  shamtOut, aluOpOut, aluSrcOut, shiftOut, regDstOut, regWriteOut, branchOut,
                  memToRegOut, memWriteOut, memReadOut, loadFullWordOut, loadSignedOut};

  id_exe_pipe_reg dut (
    .clk(clk), .reset(rst_n), .write(wr),
    .pcPlus4In(pcPlus4In), .imm32In(imm32In), .regData1In(regData1In), .regData2In(regData2In),
    .instrRtIn(instrRtIn), .instrRdIn(instrRdIn), .shamtIn(shamtIn), .aluOpIn(aluOpIn),
    .aluSrcIn(aluSrcIn), .shiftIn(shiftIn), .regDstIn(regDstIn), .regWriteIn(regWriteIn),
    .branchIn(branchIn), .memToRegIn(memToRegIn), .memWriteIn(memWriteIn),
    .memReadIn(memReadIn), .loadFullWordIn(loadFullWordIn), .loadSignedIn(loadSignedIn),
    .pcPlus4Out(pcPlus4Out), .imm32Out(imm32Out), .regData1Out(regData1Out),
    .regData2Out(regData2Out), .instrRtOut(instrRtOut), .instrRdOut(instrRdOut),
    .shamtOut(shamtOut), .aluOpOut(aluOpOut), .aluSrcOut(aluSrcOut), .shiftOut(shiftOut),
    .regDstOut(regDstOut), .regWriteOut(regWriteOut), .branchOut(branchOut),
    .memToRegOut(memToRegOut), .memWriteOut(memWriteOut), .memReadOut(memReadOut),
    .loadFullWordOut(loadFullWordOut), .loadSignedOut(loadSignedOut)
  );

  function automatic fields_t rand_fields();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[156:0];
  endfunction

  task automatic check(input string name, input fields_t act, input fields_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one edge and advance the reference: reset clears, write loads, otherwise hold.
  task automatic step(input logic r, input logic w, input fields_t d);
    rst_n = r;
    wr    = w;
    in_f  = d;
    @(posedge clk);
    if (!r)     model = '0;
    else if (w) model = d;
    #1;
  endtask

  vec_t    tbl[9];
  fields_t ones, p_first, p_stall, p_pat, zero_f;

  initial begin
    ones   = '1;
    zero_f = '0;
    p_first = '0;
    p_first.pc = 32'h4; p_first.rd = 5'd5; p_first.aluop = 4'd4; p_first.ctrl[5] = 1'b0;
    p_stall = '0;
    p_stall.pc = 32'h8; p_stall.aluop = 4'hF; p_stall.ctrl[5] = 1'b1;
    p_pat = '0;
    p_pat.pc = 32'hDEAD_BEEF; p_pat.imm = 32'hFFFF_8000; p_pat.rd1 = 32'h1234_5678;
    p_pat.rd2 = 32'hA5A5_5A5A; p_pat.rt = 5'd17; p_pat.rd = 5'd30; p_pat.shamt = 5'd9;
    p_pat.aluop = 4'hA; p_pat.ctrl = 10'b10_1100_1011;

    tbl[0] = '{1'b0, 1'b1, ones,    zero_f};
    tbl[1] = '{1'b1, 1'b1, p_first, p_first};
    tbl[2] = '{1'b1, 1'b0, p_stall, p_first};
    tbl[3] = '{1'b1, 1'b0, p_stall, p_first};
    tbl[4] = '{1'b1, 1'b0, p_stall, p_first};
    tbl[5] = '{1'b1, 1'b1, ones,    ones};
    tbl[6] = '{1'b0, 1'b1, p_pat,   zero_f};
    tbl[7] = '{1'b1, 1'b1, p_pat,   p_pat};
    tbl[8] = '{1'b0, 1'b0, p_pat,   zero_f};

    rst_n = 1'b0;
    wr    = 1'b0;
    in_f  = '0;
    model = '0;
    @(negedge clk);

    for (int unsigned i = 0; i < 9; i++) begin
      step(tbl[i].rst_n, tbl[i].wr, tbl[i].in);
      check($sformatf("vec%0d", i), out_f, tbl[i].exp);
    end

    // Spot-check individual narrow fields after an all-ones capture.
    step(1'b1, 1'b1, ones);
    checks++;
    if (aluOpOut !== 4'hF || branchOut !== 1'b1 || instrRdOut !== 5'h1F) begin
      errors++;
      $display("FAIL narrow_ones: aluOp=%h branch=%b rd=%h expected F 1 1f",
               aluOpOut, branchOut, instrRdOut);
    end

    // Random traffic with inputs, write and reset wiggled between edges.
    for (int unsigned n = 0; n < 300; n++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0), rand_fields());
      check("random", out_f, model);
      for (int unsigned k = 0; k < 2; k++) begin
        rst_n = 1'($urandom_range(0, 1));
        wr    = 1'($urandom_range(0, 1));
        in_f  = rand_fields();
        #1;
        check("midcycle", out_f, model);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
